// File: rtl/fp_div_issue.sv
// Issue queue in front of a single-outstanding FP divider: buffers requests,
// serialises them to the divider, forces a NaN completion on a hung divider.
module fp_div_issue #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 31
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [DATA_WIDTH-1:0]        req_a,
  input  logic [DATA_WIDTH-1:0]        req_b,
  input  logic [TAG_WIDTH-1:0]         req_tag,
  output logic                         div_start,
  output logic [DATA_WIDTH-1:0]        div_a,
  output logic [DATA_WIDTH-1:0]        div_b,
  input  logic [DATA_WIDTH-1:0]        div_result,
  input  logic                         div_valid,
  input  logic                         div_busy,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_WIDTH-1:0]        rsp_result,
  output logic [TAG_WIDTH-1:0]         rsp_tag,
  output logic                         rsp_timeout,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         proto_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $clog2(TIMEOUT+1);
  localparam logic [DATA_WIDTH-1:0] QNAN = DATA_WIDTH'(32'h7FC0_0000);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [TAG_WIDTH-1:0]  tag;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  req_t                  mem_q [DEPTH];
  req_t                  mem_d [DEPTH];
  req_t                  opr_q, opr_d;
  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         wcnt_q, wcnt_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  tmo_q, tmo_d;
  logic                  perr_q, perr_d;
  logic                  push, pop;

  // Ready comes from the registered count only; a full queue never bypasses.
  assign req_ready = rst_n && (cnt_q < CW'(DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = (state_q == IDLE) && (cnt_q != '0) && !div_busy;

  assign occupancy   = cnt_q;
  assign div_a       = opr_q.a;
  assign div_b       = opr_q.b;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_result  = res_q;
  assign rsp_tag     = opr_q.tag;
  assign rsp_timeout = tmo_q;
  assign proto_err   = perr_q;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      mem_d[wptr_q] = '{a: req_a, b: req_b, tag: req_tag};
      wptr_d        = wptr_q + PW'(1);
    end
    if (pop) rptr_d = rptr_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    opr_d     = opr_q;
    wcnt_d    = wcnt_q;
    res_d     = res_q;
    tmo_d     = tmo_q;
    perr_d    = perr_q || (div_valid && (state_q != WAIT));
    div_start = 1'b0;
    case (state_q)
      IDLE: if (pop) begin
        opr_d   = mem_q[rptr_q];
        state_d = ISSUE;
      end
      ISSUE: begin
        div_start = 1'b1;
        wcnt_d    = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        // A result arriving on the timeout cycle still wins.
        if (div_valid) begin
          res_d   = div_result;
          tmo_d   = 1'b0;
          state_d = RESP;
        end else begin
          wcnt_d = wcnt_q + TW'(1);
          if (wcnt_d == TW'(TIMEOUT)) begin
            res_d   = QNAN;
            tmo_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opr_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      res_q   <= '0;
      tmo_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opr_q   <= opr_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      res_q   <= res_d;
      tmo_q   <= tmo_d;
      perr_q  <= perr_d;
    end
  end

  // Queue storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_fp_div_issue.sv
// Directed bench for fp_div_issue with a small delay-programmable divider model.
module tb_fp_div_issue;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0, req_b = '0;
  logic [5:0]  req_tag = '0;
  logic        div_start;
  logic [31:0] div_a, div_b;
  logic [31:0] div_result;
  logic        div_valid;
  logic        div_busy = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [5:0]  rsp_tag;
  logic        rsp_timeout;
  logic [2:0]  occupancy;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  fp_div_issue #(.DATA_WIDTH(32), .TAG_WIDTH(6), .DEPTH(4), .TIMEOUT(31)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_result(div_result), .div_valid(div_valid), .div_busy(div_busy),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout),
    .occupancy(occupancy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Divider model: div_valid in cycle start+dly_cfg; dly_cfg==0 never answers.
  int          dly_cfg = 6;
  logic [31:0] res_cfg = '0;
  bit          pend = 1'b0;
  int          mcnt = 0;
  logic        mdl_vld = 1'b0;
  logic        spur = 1'b0;
  assign div_valid  = mdl_vld | spur;
  assign div_result = res_cfg;

  always @(negedge clk) begin
    mdl_vld <= 1'b0;
    if (div_start) begin
      pend <= 1'b1;
      mcnt <= 1;
    end else if (pend) begin
      if (dly_cfg > 0 && mcnt == dly_cfg) begin
        mdl_vld <= 1'b1;
        pend    <= 1'b0;
      end else mcnt <= mcnt + 1;
    end
  end

  int cyc = 0, starts = 0, start_cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (div_start) begin
      starts    <= starts + 1;
      start_cyc <= cyc;
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [5:0] t);
    req_valid = 1'b1; req_a = a; req_b = b; req_tag = t;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic take();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", req_ready); end
    checks++; if ({div_start, rsp_valid, rsp_timeout, proto_err} !== 4'b0) begin errors++; $display("FAIL rst_ctl got %b exp 0000", {div_start, rsp_valid, rsp_timeout, proto_err}); end
    checks++; if ({div_a, div_b, rsp_result, rsp_tag} !== '0) begin errors++; $display("FAIL rst_data got %h/%h/%h/%h exp 0", div_a, div_b, rsp_result, rsp_tag); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rst_occ got %0d exp 0", occupancy); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b exp 1", req_ready); end
  endtask

  task automatic test_single();
    bit ok; int s0;
    dly_cfg = 6; res_cfg = 32'h4040_0000; s0 = starts;
    push(32'h40C0_0000, 32'h4000_0000, 6'd5);
    checks++; if ({occupancy, div_start} !== {3'd1, 1'b0}) begin errors++; $display("FAIL single_n1 got occ %0d start %b exp 1 0", occupancy, div_start); end
    @(negedge clk);
    checks++; if ({div_start, div_a, div_b} !== {1'b1, 32'h40C0_0000, 32'h4000_0000}) begin errors++; $display("FAIL single_issue got %b %h %h exp 1 40c00000 40000000", div_start, div_a, div_b); end
    wait_rsp(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_wait got no rsp_valid exp rsp_valid"); end
    checks++; if ({rsp_result, rsp_tag, rsp_timeout} !== {32'h4040_0000, 6'd5, 1'b0}) begin errors++; $display("FAIL single_rsp got %h %0d %b exp 40400000 5 0", rsp_result, rsp_tag, rsp_timeout); end
    checks++; if (cyc - start_cyc !== 7) begin errors++; $display("FAIL single_lat got %0d exp 7", cyc - start_cyc); end
    checks++; if (starts - s0 !== 1) begin errors++; $display("FAIL single_starts got %0d exp 1", starts - s0); end
    take();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drop got %b exp 0", rsp_valid); end
  endtask

  task automatic test_fill();
    bit ok; int acc, s0;
    div_busy = 1'b1; dly_cfg = 3; acc = 0; s0 = starts;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_a = 32'(i); req_b = 32'h3F80_0000; req_tag = 6'(i);
      if (req_ready) acc++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    checks++; if (acc !== 4) begin errors++; $display("FAIL fill_acc got %0d exp 4", acc); end
    checks++; if ({occupancy, req_ready} !== {3'd4, 1'b0}) begin errors++; $display("FAIL fill_full got occ %0d rdy %b exp 4 0", occupancy, req_ready); end
    checks++; if (starts !== s0) begin errors++; $display("FAIL fill_busy got %0d exp %0d", starts, s0); end
    div_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_rsp(ok);
      checks++; if ({ok, rsp_tag, div_a} !== {1'b1, 6'(i), 32'(i)}) begin errors++; $display("FAIL fill_order got ok %b tag %0d a %h exp 1 %0d %h", ok, rsp_tag, div_a, i, i); end
      take();
    end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL fill_empty got %0d exp 0", occupancy); end
  endtask

  task automatic test_backpressure();
    bit ok; int s0;
    dly_cfg = 2; res_cfg = 32'h3F80_0000;
    push(32'h3F80_0000, 32'h3F80_0000, 6'd9);
    wait_rsp(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_wait got no rsp_valid exp rsp_valid"); end
    s0 = starts;
    push(32'h4000_0000, 32'h3F80_0000, 6'd10);
    for (int i = 0; i < 9; i++) begin
      checks++; if ({rsp_valid, rsp_result, rsp_tag} !== {1'b1, 32'h3F80_0000, 6'd9}) begin errors++; $display("FAIL bp_hold got %b %h %0d exp 1 3f800000 9", rsp_valid, rsp_result, rsp_tag); end
      @(negedge clk);
    end
    checks++; if ({starts - s0, occupancy} !== {32'd0, 3'd1}) begin errors++; $display("FAIL bp_nostart got starts %0d occ %0d exp 0 1", starts - s0, occupancy); end
    take();
    wait_rsp(ok);
    checks++; if ({ok, rsp_tag} !== {1'b1, 6'd10}) begin errors++; $display("FAIL bp_second got %b %0d exp 1 10", ok, rsp_tag); end
    take();
  endtask

  task automatic test_timeout();
    bit ok;
    dly_cfg = 0; res_cfg = 32'h1234_5678;
    push(32'h4000_0000, 32'h0, 6'd7);
    push(32'h4100_0000, 32'h4000_0000, 6'd8);
    wait_rsp(ok);
    checks++; if ({ok, rsp_result, rsp_timeout, rsp_tag} !== {1'b1, 32'h7FC0_0000, 1'b1, 6'd7}) begin errors++; $display("FAIL tmo_rsp got %b %h %b %0d exp 1 7fc00000 1 7", ok, rsp_result, rsp_timeout, rsp_tag); end
    checks++; if (cyc - start_cyc !== 32) begin errors++; $display("FAIL tmo_lat got %0d exp 32", cyc - start_cyc); end
    dly_cfg = 31;
    take();
    wait_rsp(ok);
    checks++; if ({ok, rsp_result, rsp_timeout, rsp_tag} !== {1'b1, 32'h1234_5678, 1'b0, 6'd8}) begin errors++; $display("FAIL tmo_edge got %b %h %b %0d exp 1 12345678 0 8", ok, rsp_result, rsp_timeout, rsp_tag); end
    checks++; if (cyc - start_cyc !== 32) begin errors++; $display("FAIL tmo_edge_lat got %0d exp 32", cyc - start_cyc); end
    take();
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL tmo_perr got %b exp 0", proto_err); end
  endtask

  task automatic test_busy();
    bit ok; int s0;
    div_busy = 1'b1; dly_cfg = 2; res_cfg = 32'h4000_0000;
    push(32'h1, 32'h2, 6'd1);
    push(32'h3, 32'h4, 6'd2);
    s0 = starts;
    repeat (6) @(negedge clk);
    checks++; if ({occupancy, 32'(starts - s0)} !== {3'd2, 32'd0}) begin errors++; $display("FAIL busy_gate got occ %0d starts %0d exp 2 0", occupancy, starts - s0); end
    div_busy = 1'b0;
    @(negedge clk);
    checks++; if ({div_start, div_a} !== {1'b1, 32'h1}) begin errors++; $display("FAIL busy_release got %b %h exp 1 1", div_start, div_a); end
    for (int i = 1; i < 3; i++) begin
      wait_rsp(ok);
      checks++; if ({ok, rsp_tag} !== {1'b1, 6'(i)}) begin errors++; $display("FAIL busy_rsp got %b %0d exp 1 %0d", ok, rsp_tag, i); end
      take();
    end
  endtask

  task automatic test_spurious();
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL spur_set got %b exp 1", proto_err); end
    repeat (3) @(negedge clk);
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL spur_sticky got %b exp 1", proto_err); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if ({proto_err, occupancy} !== {1'b0, 3'd0}) begin errors++; $display("FAIL spur_clear got %b %0d exp 0 0", proto_err, occupancy); end
    dly_cfg = 8;
    push(32'h5, 32'h6, 6'd3);
    push(32'h7, 32'h8, 6'd4);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if ({occupancy, rsp_valid, proto_err} !== {3'd0, 1'b0, 1'b0}) begin errors++; $display("FAIL midrst got occ %0d vld %b perr %b exp 0 0 0", occupancy, rsp_valid, proto_err); end
    repeat (10) @(negedge clk);
    checks++; if ({proto_err, rsp_valid} !== {1'b1, 1'b0}) begin errors++; $display("FAIL midrst_late got perr %b vld %b exp 1 0", proto_err, rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_backpressure();
    test_timeout();
    test_busy();
    test_spurious();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
